// File: rtl/rfalu_pkg.sv
// rtl/rfalu_pkg.sv - ALU opcodes and retire FSM states shared by the datapath
package rfalu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SGE = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    REQ = 2'd1,
    RSP = 2'd2
  } state_t;

endpackage

// File: rtl/rfalu_alu.sv
// rtl/rfalu_alu.sv - combinational ALU with zero, signed-overflow and carry flags
module rfalu_alu
  import rfalu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
) (
  input  logic [CTRL_BITS-1:0]  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  over,
  output logic                  c_out
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                lt;

  // Subtraction is a + ~b + 1 so the top bit is carry, i.e. NOT borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
  assign lt   = $signed(a) < $signed(b);

  // Opcode decode; flags other than zero are only meaningful for ADD/SUB.
  always_comb begin
    result = '0;
    over   = 1'b0;
    c_out  = 1'b0;
    case (op)
      CTRL_BITS'(OP_AND): result = a & b;
      CTRL_BITS'(OP_OR):  result = a | b;
      CTRL_BITS'(OP_ADD): begin
        result = sum[MSB:0];
        c_out  = sum[DATA_WIDTH];
        over   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      CTRL_BITS'(OP_SUB): begin
        result = diff[MSB:0];
        c_out  = diff[DATA_WIDTH];
        over   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      CTRL_BITS'(OP_SLT): result = {{(DATA_WIDTH-1){1'b0}}, lt};
      CTRL_BITS'(OP_SGE): result = {{(DATA_WIDTH-1){1'b0}}, ~lt};
      CTRL_BITS'(OP_NOR): result = ~(a | b);
      default:            result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rfalu_mem_pipe.sv
// rtl/rfalu_mem_pipe.sv - two-stage regfile/ALU/memory datapath; RFALU_FWD_EN enables X-stage forwarding
module rfalu_mem_pipe
  import rfalu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int ADDR_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NAME_BITS-1:0]  rs1,
  input  logic [NAME_BITS-1:0]  rs2,
  input  logic [NAME_BITS-1:0]  ws,
  input  logic [CTRL_BITS-1:0]  op,
  input  logic                  imm_e,
  input  logic [DATA_WIDTH-1:0] imm_d,
  input  logic                  ld,
  input  logic                  st,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                  wb_valid,
  output logic [NAME_BITS-1:0]  wb_ws,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  zero,
  output logic                  over,
  output logic                  c_out
);

  localparam int NREGS = 2 ** NAME_BITS;

  logic [DATA_WIDTH-1:0] rf [NREGS];
  state_t                state;

  logic                  x_valid;
  logic [NAME_BITS-1:0]  x_ws;
  logic [DATA_WIDTH-1:0] x_result;
  logic [DATA_WIDTH-1:0] x_rs2;
  logic                  x_ld;
  logic                  x_st;
  logic                  x_zero;
  logic                  x_over;
  logic                  x_cout;

  logic                  x_alu;
  logic                  rs1_hit;
  logic                  rs2_hit;
  logic                  hazard;
  logic                  issue;
  logic [DATA_WIDTH-1:0] rf_rd1;
  logic [DATA_WIDTH-1:0] rf_rd2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_over;
  logic                  alu_cout;
  logic                  rf_we;

  // In RUN the X stage only ever holds ALU ops; mem ops leave RUN on issue.
  assign x_alu   = x_valid && !x_ld && !x_st;
  assign rs1_hit = x_alu && (x_ws != '0) && (rs1 == x_ws);
  assign rs2_hit = x_alu && (x_ws != '0) && (rs2 == x_ws);

  assign rf_rd1 = (rs1 == '0) ? '0 : rf[rs1];
  assign rf_rd2 = (rs2 == '0) ? '0 : rf[rs2];

`ifdef RFALU_FWD_EN
  assign hazard = 1'b0;
  assign rd1    = rs1_hit ? x_result : rf_rd1;
  assign rd2    = rs2_hit ? x_result : rf_rd2;
`else
  // rs2 only matters when it feeds the ALU or supplies store data.
  assign hazard = rs1_hit || (rs2_hit && (st || !imm_e));
  assign rd1    = rf_rd1;
  assign rd2    = rf_rd2;
`endif

  assign alu_b    = imm_e ? imm_d : rd2;
  assign in_ready = (state == RUN) && !hazard;
  assign issue    = in_valid && in_ready;

  rfalu_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_BITS  (CTRL_BITS)
  ) u_alu (
    .op     (op),
    .a      (rd1),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero),
    .over   (alu_over),
    .c_out  (alu_cout)
  );

  // Request fields come straight from the X register, so they hold while stalled.
  assign mem_req_valid = (state == REQ);
  assign mem_req_we    = x_st;
  assign mem_req_addr  = x_result[ADDR_BITS-1:0];
  assign mem_req_wdata = x_rs2;

  assign wb_valid = ((state == RUN) && x_alu) || ((state == RSP) && mem_rsp_valid);
  assign wb_ws    = x_ws;
  assign wb_data  = (state == RSP) ? mem_rsp_rdata : x_result;
  assign rf_we    = wb_valid && (x_ws != '0);

  // Register file: single write port fed by the retire path; r0 never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (rf_we) begin
      rf[x_ws] <= wb_data;
    end
  end

  // Retire FSM, X stage and architectural flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      x_valid  <= 1'b0;
      x_ws     <= '0;
      x_result <= '0;
      x_rs2    <= '0;
      x_ld     <= 1'b0;
      x_st     <= 1'b0;
      x_zero   <= 1'b0;
      x_over   <= 1'b0;
      x_cout   <= 1'b0;
      zero     <= 1'b0;
      over     <= 1'b0;
      c_out    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (x_alu) begin
            zero    <= x_zero;
            over    <= x_over;
            c_out   <= x_cout;
            x_valid <= 1'b0;
          end
          if (issue) begin
            x_valid  <= 1'b1;
            x_ws     <= ws;
            x_result <= alu_result;
            x_rs2    <= rd2;
            x_ld     <= ld && !st;
            x_st     <= st;
            x_zero   <= alu_zero;
            x_over   <= alu_over;
            x_cout   <= alu_cout;
            if (ld || st) begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            if (x_st) begin
              x_valid <= 1'b0;
              state   <= RUN;
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            x_valid <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rfalu_mem_pipe.sv
// tb/tb_rfalu_mem_pipe.sv - scoreboard bench for rfalu_mem_pipe
module tb_rfalu_mem_pipe;
  import rfalu_pkg::*;

`ifdef RFALU_FWD_EN
  localparam int DEP_STALLS = 0;
`else
  localparam int DEP_STALLS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1, rs2, ws;
  logic [3:0]  op;
  logic        imm_e;
  logic [31:0] imm_d;
  logic        ld, st;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_ws;
  logic [31:0] wb_data;
  logic        zero, over, c_out;

  typedef struct packed {
    logic [4:0]  ws;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rfalu_mem_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .ws            (ws),
    .op            (op),
    .imm_e         (imm_e),
    .imm_d         (imm_d),
    .ld            (ld),
    .st            (st),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .wb_valid      (wb_valid),
    .wb_ws         (wb_ws),
    .wb_data       (wb_data),
    .zero          (zero),
    .over          (over),
    .c_out         (c_out)
  );

  // Every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected ws=%0d data=%h required no write-back", wb_ws, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wb_ws !== e.ws || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_data ws=%0d data=%h required ws=%0d data=%h", wb_ws, wb_data, e.ws, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] w, input logic [31:0] d);
    exp_t e;
    e.ws   = w;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] t_ws, input logic [4:0] t_rs1, input logic [4:0] t_rs2,
                       input logic [3:0] t_op, input logic t_imm_e, input logic [31:0] t_imm,
                       input logic t_ld, input logic t_st, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    ws = t_ws; rs1 = t_rs1; rs2 = t_rs2; op = t_op;
    imm_e = t_imm_e; imm_d = t_imm; ld = t_ld; st = t_st;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout ws=%0d in_ready=%b required 1", t_ws, in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ld = 1'b0; st = 1'b0;
  endtask

  task automatic op_imm(input logic [4:0] w, input logic [4:0] r1, input logic [3:0] o,
                        input logic [31:0] imm, input logic [31:0] exp_d, output int stalls);
    push_exp(w, exp_d);
    issue(w, r1, 5'd0, o, 1'b1, imm, 1'b0, 1'b0, stalls);
  endtask

  task automatic check_flags(input string name, input logic ez, input logic eo, input logic ec);
    @(posedge clk); #1;
    checks++;
    if (zero !== ez || over !== eo || c_out !== ec) begin
      errors++;
      $display("FAIL %s zero/over/c_out=%b%b%b required %b%b%b", name, zero, over, c_out, ez, eo, ec);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required 1", in_ready); end
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got=%b required 0", mem_req_valid); end
    checks++;
    if (wb_valid !== 1'b0 || wb_ws !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL reset_wb got=%b/%0d/%h required 0/0/00000000", wb_valid, wb_ws, wb_data);
    end
    checks++;
    if ({zero, over, c_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b%b%b required 000", zero, over, c_out); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_basic;
    int s;
    op_imm(5'd1, 5'd0, OP_OR, 32'd5, 32'd5, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL basic_stall got=%0d required 0", s); end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_timing wb_valid=%b required 1", wb_valid); end
    check_flags("basic_flags", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dependent;
    int s0, s1;
    op_imm(5'd2, 5'd1, OP_ADD, 32'd3, 32'd8, s0);
    op_imm(5'd3, 5'd2, OP_ADD, 32'd1, 32'd9, s1);
    checks++;
    if (s1 != DEP_STALLS) begin errors++; $display("FAIL dep_stall got=%0d required %0d", s1, DEP_STALLS); end
  endtask

  task automatic test_store;
    int s;
    mem_req_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd3, OP_ADD, 1'b1, 32'h10, 1'b0, 1'b1, s);
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 16'h0010 ||
          mem_req_wdata !== 32'd9 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL store_req cycle=%0d v/we/addr/wdata/in_ready=%b/%b/%h/%h/%b required 1/1/0010/00000009/0",
                 i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, in_ready);
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL store_done in_ready=%b mem_req_valid=%b required 1 0", in_ready, mem_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    int s;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL stray_rsp_run wb_valid=%b required 0", wb_valid); end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    issue(5'd4, 5'd0, 5'd0, OP_ADD, 1'b1, 32'h10, 1'b1, 1'b0, s);
    mem_rsp_valid = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 16'h0010 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL load_req v/we/addr/wb=%b/%b/%h/%b required 1/0/0010/0", mem_req_valid, mem_req_we, mem_req_addr, wb_valid);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL load_wait in_ready/req/wb=%b/%b/%b required 0/0/0", in_ready, mem_req_valid, wb_valid);
    end
    @(posedge clk); #1;
    push_exp(5'd4, 32'hDEADBEEF);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL load_wb_timing wb_valid=%b required 1", wb_valid); end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready got=%b required 1", in_ready); end
    @(posedge clk); #1;
    op_imm(5'd15, 5'd4, OP_OR, 32'd0, 32'hDEADBEEF, s);
  endtask

  task automatic test_flags;
    int s;
    op_imm(5'd6, 5'd0, OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, s);
    op_imm(5'd7, 5'd6, OP_ADD, 32'd1, 32'h80000000, s);
    check_flags("add_overflow", 1'b0, 1'b1, 1'b0);
    op_imm(5'd9, 5'd0, OP_OR, 32'd5, 32'd5, s);
    op_imm(5'd10, 5'd9, OP_SUB, 32'd5, 32'd0, s);
    check_flags("sub_zero", 1'b1, 1'b0, 1'b1);
    op_imm(5'd11, 5'd0, OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, s);
    op_imm(5'd12, 5'd11, OP_SLT, 32'd1, 32'd1, s);
    check_flags("slt_flags", 1'b0, 1'b0, 1'b0);
    push_exp(5'd13, 32'hFFFFFFFD);
    issue(5'd13, 5'd1, 5'd2, OP_SUB, 1'b0, 32'd0, 1'b0, 1'b0, s);
    check_flags("sub_borrow", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int s, total;
    total = 0;
    op_imm(5'd20, 5'd0, OP_AND, 32'hFF, 32'd0, s);        total += s;
    op_imm(5'd21, 5'd0, OP_OR, 32'hA5, 32'hA5, s);        total += s;
    op_imm(5'd22, 5'd0, OP_SGE, 32'hFFFFFFFF, 32'd1, s);  total += s;
    op_imm(5'd23, 5'd0, OP_NOR, 32'h0F, 32'hFFFFFFF0, s); total += s;
    op_imm(5'd24, 5'd0, 4'b1111, 32'h55, 32'd0, s);       total += s;
    op_imm(5'd0, 5'd0, OP_OR, 32'd7, 32'd7, s);           total += s;
    push_exp(5'd25, 32'd0);
    issue(5'd25, 5'd0, 5'd0, OP_OR, 1'b0, 32'd0, 1'b0, 1'b0, s);
    total += s;
    push_exp(5'd26, 32'd3);
    issue(5'd26, 5'd0, 5'd25, OP_OR, 1'b1, 32'd3, 1'b0, 1'b0, s);
    total += s;
    checks++;
    if (total != 0) begin errors++; $display("FAIL b2b_stalls got=%0d required 0", total); end
  endtask

  task automatic test_reset_in_req;
    int s;
    mem_req_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd3, OP_ADD, 1'b1, 32'h20, 1'b0, 1'b1, s);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%b required 1", mem_req_valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_async_drop got=%b required 0", mem_req_valid); end
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h00000BAD;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after in_ready=%b mem_req_valid=%b required 1 0", in_ready, mem_req_valid);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    op_imm(5'd5, 5'd4, OP_OR, 32'd0, 32'd0, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; ws = '0; op = '0;
    imm_e = 1'b0; imm_d = '0; ld = 1'b0; st = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    test_reset;
    test_alu_basic;
    test_dependent;
    test_store;
    test_load;
    test_flags;
    test_back_to_back;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size()); end
    test_reset_in_req;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain left=%0d required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
